bias_send: RTL and testbench

Transmit side of the bias path: on a layer start it reads the layer's packed bias words from the on-chip bias RAM and streams them as 128-bit beats on the `bias_in_vld` / `bias_in` interface consumed by `bias_ctrl`. It runs in the 200 MHz domain and sits between the bias RAM and the bias packing/FIFO stage. Each 512-bit RAM word holds 16 × 32-bit channel biases and is sent as exactly 4 consecutive beats. RAM reads are prefetched so a layer's beats are gap-free.

---
 rtl/bias_send.sv | 113 +++++++++++
 tb/tb_bias_send.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bias_send.sv
// bias_send: streams a layer's packed bias words from the bias RAM as gap-free 128-bit beats
// Ports:
//   clk_200M, rst                      clock and synchronous active-high reset
//   start, ch_num, base_addr           layer request; parameters are sampled with start
//   busy, done                         layer in progress / one-cycle completion pulse
//   ram_rd_en, ram_rd_addr, ram_rd_data  bias RAM read port, data valid RD_LAT cycles after ram_rd_en
//   bias_in_vld, bias_in               beat stream to bias_ctrl, always accepted
// Optional: define BIAS_SEND_ZERO_PAD_EN to zero the lanes of channels >= ch_num in the last word.
module bias_send #(
    parameter int AW = 10,
    parameter int RD_LAT = 2
) (
    input  logic          clk_200M,
    input  logic          rst,
    input  logic          start,
    input  logic [15:0]   ch_num,
    input  logic [AW-1:0] base_addr,
    output logic          busy,
    output logic          done,
    output logic          ram_rd_en,
    output logic [AW-1:0] ram_rd_addr,
    input  logic [511:0]  ram_rd_data,
    output logic          bias_in_vld,
    output logic [127:0]  bias_in
);
    localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, SEND = 2'd2, FIN = 2'd3;
    logic [1:0] r_state, r_beat;
    logic [11:0] r_nw, r_idx;
    logic [511:0] r_word, r_hold;
    logic [RD_LAT-1:0] r_rd_pipe;
    logic r_rd_en;
    logic [AW-1:0] r_addr;
    logic w_rd_vld, w_last, w_more;
    logic [511:0] w_load_raw, w_load;

    // r_rd_pipe tracks outstanding reads, so RAM data with no read behind it is ignored
    assign w_rd_vld = r_rd_pipe[RD_LAT-1];
    assign w_last = r_idx == r_nw - 12'd1;
    // whether the word being loaded (0 in FILL, r_idx+1 in SEND) has a successor to prefetch
    assign w_more = r_state == FILL ? r_nw != 12'd1 : r_idx + 12'd2 != r_nw;
    // at RD_LAT=3 the prefetched word lands in the beat-3 cycle, so bypass the holding register
    assign w_load_raw = (r_state == FILL || w_rd_vld) ? ram_rd_data : r_hold;

`ifdef BIAS_SEND_ZERO_PAD_EN
    logic [15:0] r_ch;
    logic [11:0] w_load_idx;
    assign w_load_idx = r_state == FILL ? 12'd0 : r_idx + 12'd1;
    // channel of lane j is {word index, j}; earlier words never exceed ch_num
    always_comb begin
        w_load = w_load_raw;
        for (int j = 0; j < 16; j++)
            if ({w_load_idx, 4'(j)} >= r_ch) w_load[32*j +: 32] = '0;
    end
`else
    assign w_load = w_load_raw;
`endif

    always_ff @(posedge clk_200M) begin
        if (rst) begin
            r_state <= IDLE;
            r_beat <= '0;
            r_nw <= '0;
            r_idx <= '0;
            r_rd_pipe <= '0;
            r_rd_en <= 1'b0;
            r_addr <= '0;
        end else begin
            r_rd_pipe[0] <= r_rd_en;
            for (int i = 1; i < RD_LAT; i++) r_rd_pipe[i] <= r_rd_pipe[i-1];
            r_rd_en <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_nw <= 12'((ch_num + 16'd15) >> 4);
`ifdef BIAS_SEND_ZERO_PAD_EN
                    r_ch <= ch_num;
`endif
                    r_idx <= '0;
                    r_beat <= '0;
                    r_addr <= base_addr;
                    r_rd_en <= ch_num != 16'd0;
                    r_state <= ch_num != 16'd0 ? FILL : FIN;
                end
                FILL: if (w_rd_vld) begin
                    r_word <= w_load;
                    r_state <= SEND;
                    r_rd_en <= w_more;
                    if (w_more) r_addr <= r_addr + AW'(1);
                end
                SEND: begin
                    r_beat <= r_beat + 2'd1;
                    if (w_rd_vld) r_hold <= ram_rd_data;
                    if (r_beat == 2'd3) begin
                        if (w_last) r_state <= FIN;
                        else begin
                            r_idx <= r_idx + 12'd1;
                            r_word <= w_load;
                            r_rd_en <= w_more;
                            if (w_more) r_addr <= r_addr + AW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_state != IDLE;
    assign done = r_state == FIN;
    assign bias_in_vld = r_state == SEND;
    assign bias_in = bias_in_vld ? r_word[{r_beat, 7'd0} +: 128] : '0;
    assign ram_rd_en = r_rd_en;
    assign ram_rd_addr = r_addr;
endmodule

// File: tb/tb_bias_send.sv
// tb_bias_send: table-driven scoreboard bench running bias_send at RD_LAT 1, 2 and 3 side by side
module tb_bias_send;
    localparam int AW = 10;
    typedef struct { logic [15:0] ch; logic [AW-1:0] base; int fill; bit mid; int nw; } vec_t;
    typedef struct { logic [127:0] d; int c; } beat_t;
    typedef struct { logic [AW-1:0] a; int c; } rd_t;

    logic clk = 0, rst = 1, start = 0;
    logic [15:0] ch_num = 0;
    logic [AW-1:0] base_addr = 0;
    logic busy [3], done [3], rd_en [3], vld [3];
    logic [AW-1:0] rd_addr [3];
    logic [127:0] bin [3];
    logic [511:0] rdata [3];
    logic [511:0] pipe [3][3];
    logic [511:0] mem [1 << AW];
    beat_t bq [3][$];
    rd_t aq [3][$];
    int edone [3];
    int cyc = 0, st_cyc = 0, checks = 0, errors = 0;
    bit on = 0, zchk = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        bias_send #(.AW(AW), .RD_LAT(g + 1)) u_dut (
            .clk_200M(clk), .rst(rst), .start(start), .ch_num(ch_num), .base_addr(base_addr),
            .busy(busy[g]), .done(done[g]), .ram_rd_en(rd_en[g]), .ram_rd_addr(rd_addr[g]),
            .ram_rd_data(rdata[g]), .bias_in_vld(vld[g]), .bias_in(bin[g]));
        assign rdata[g] = pipe[g][g];
    end

    // RAM model: junk on the bus whenever no read was issued
    always @(posedge clk)
        for (int k = 0; k < 3; k++) begin
            pipe[k][0] <= rd_en[k] ? mem[rd_addr[k]] : {16{$urandom}};
            pipe[k][1] <= pipe[k][0];
            pipe[k][2] <= pipe[k][1];
        end

    task automatic chk(input string nm, input int k, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lat%0d: got %h, expected %h", nm, k + 1, act, exp);
        end
    endtask

    task automatic mon();
        int rel;
        beat_t b;
        rd_t r;
        bit eb, ed;
        rel = cyc - st_cyc;
        for (int k = 0; k < 3; k++) begin
            eb = on && rel >= 1 && rel <= edone[k];
            ed = on && rel == edone[k];
            if (zchk) chk("reset_outputs", k, 192'({busy[k], done[k], rd_en[k], rd_addr[k], vld[k], bin[k]}), '0);
            chk("busy", k, 192'(busy[k]), 192'(eb));
            chk("done", k, 192'(done[k]), 192'(ed));
            if (rd_en[k]) begin
                r.a = '1;
                r.c = -1;
                if (aq[k].size() != 0) r = aq[k].pop_front();
                chk("read_addr_cycle", k, 192'({rd_addr[k], rel}), 192'({r.a, r.c}));
            end
            if (vld[k]) begin
                b.d = '0;
                b.c = -1;
                if (bq[k].size() != 0) b = bq[k].pop_front();
                chk("beat_data_cycle", k, 192'({bin[k], rel}), 192'({b.d, b.c}));
            end else chk("idle_bias_zero", k, 192'(bin[k]), '0);
            if (ed) begin
                chk("reads_left", k, 192'(aq[k].size()), '0);
                chk("beats_left", k, 192'(bq[k].size()), '0);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        mon();
    endtask

    task automatic launch(input vec_t v);
        logic [511:0] w;
        logic [AW-1:0] a;
        for (int i = 0; i < v.nw; i++) begin
            a = v.base + AW'(i);
            for (int b = 0; b < 64; b++)
                w[8*b +: 8] = v.fill == 0 ? 8'(64 * i + b) : v.fill == 1 ? 8'hff : 8'($urandom);
            mem[a] = w;
        end
        for (int k = 0; k < 3; k++) begin
            aq[k].delete();
            bq[k].delete();
            edone[k] = v.nw == 0 ? 1 : 3 + k + 4 * v.nw;
            for (int i = 0; i < v.nw; i++) begin
                a = v.base + AW'(i);
                aq[k].push_back('{a: a, c: i == 0 ? 1 : 3 + k + 4 * (i - 1)});
                w = mem[a];
`ifdef BIAS_SEND_ZERO_PAD_EN
                for (int j = 0; j < 16; j++) if (16 * i + j >= int'(v.ch)) w[32*j +: 32] = '0;
`endif
                for (int b = 0; b < 4; b++) bq[k].push_back('{d: w[128*b +: 128], c: 3 + k + 4 * i + b});
            end
        end
        start = 1;
        ch_num = v.ch;
        base_addr = v.base;
        st_cyc = cyc;
        on = 1;
    endtask

    task automatic run_layer(input vec_t v);
        int rel;
        bit fin;
        launch(v);
        fin = 0;
        for (int t = 0; t < 200 && !fin; t++) begin
            step();
            rel = cyc - st_cyc;
            if (rel == 1 || rel == 4) start = 0;
            if (v.mid && rel == 3) begin
                start = 1;
                ch_num = 16'd64;
                base_addr = 10'h300;
            end
            fin = rel > 1 && !busy[0] && !busy[1] && !busy[2];
        end
        chk("layer_terminates", 0, 192'(fin), 192'd1);
        step();
    endtask

    initial begin
        vec_t vt [7];
        vec_t vr;
        vt[0] = '{ch: 16'd16, base: 10'h010, fill: 0, mid: 0, nw: 1};
        vt[1] = '{ch: 16'd40, base: 10'h100, fill: 2, mid: 0, nw: 3};
        vt[2] = '{ch: 16'd20, base: 10'h200, fill: 1, mid: 0, nw: 2};
        vt[3] = '{ch: 16'd0,  base: 10'h050, fill: 2, mid: 0, nw: 0};
        vt[4] = '{ch: 16'd32, base: 10'h3ff, fill: 2, mid: 0, nw: 2};
        vt[5] = '{ch: 16'd17, base: 10'h020, fill: 2, mid: 1, nw: 2};
        vt[6] = '{ch: 16'd33, base: 10'h040, fill: 0, mid: 0, nw: 3};
        vr = '{ch: 16'd32, base: 10'h080, fill: 2, mid: 0, nw: 2};
        zchk = 1;
        repeat (3) step();
        rst = 0;
        step();
        zchk = 0;
        for (int i = 0; i < 7; i++) run_layer(vt[i]);
        launch(vr);
        for (int t = 0; t < 10; t++) begin
            step();
            if (t == 0) start = 0;
        end
        rst = 1;
        on = 0;
        zchk = 1;
        step();
        rst = 0;
        step();
        step();
        zchk = 0;
        run_layer(vr);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
